// File: rtl/disp_share_arbiter.sv
// Shares one 8-digit seven-segment driver between four requesters.
// Requester 0 preempts; requesters 1-3 rotate round-robin after a minimum hold.
module disp_share_arbiter #(
    parameter int          MIN_HOLD   = 100_000_000,
    parameter logic [31:0] IDLE_VALUE = 32'h0000_0000,
    parameter int          CNT_W      = $clog2(MIN_HOLD + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [127:0] data,
    output logic [3:0]   grant,
    output logic [1:0]   owner,
    output logic         busy,
    output logic [31:0]  number,
    output logic         chg
);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_SLICE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         grant_q, grant_d;
    logic [1:0]         owner_q, owner_d;
    logic [31:0]        number_q, number_d;
    logic               chg_q, chg_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [1:0]         rr_q, rr_d;

    logic [31:0]        words [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign words[gi] = data[32*gi +: 32];
    end

    // Returns {found, index}; scans 1..3 starting after 'last', skipping 'excl'.
    function automatic logic [2:0] rr_search(input logic [3:0] r, input logic [1:0] last,
                                             input logic [1:0] excl);
        logic [2:0] res;
        logic [1:0] cand;
        res = {1'b0, last};
        for (int k = 2; k >= 0; k--) begin
            cand = 2'((int'(last) + k) % 3 + 1);
            if (r[cand] && cand != excl)
                res = {1'b1, cand};
        end
        return res;
    endfunction

    logic [2:0] sel_rr, rot_rr;
    logic       sel_valid;
    logic [1:0] sel_idx;
    logic       take;
    logic [1:0] take_idx;

    always_comb begin
        sel_rr    = rr_search(req, rr_q, 2'd0);
        rot_rr    = rr_search(req, rr_q, owner_q);
        sel_valid = req[0] | sel_rr[2];
        sel_idx   = req[0] ? 2'd0 : sel_rr[1:0];

        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        number_d = number_q;
        hold_d   = hold_q;
        rr_d     = rr_q;
        take     = 1'b0;
        take_idx = 2'd0;

        case (state_q)
            ST_IDLE: begin
                number_d = IDLE_VALUE;
                if (sel_valid) begin
                    take     = 1'b1;
                    take_idx = sel_idx;
                end
            end
            default: begin
                number_d = words[owner_q];
                if (req[0] && owner_q != 2'd0) begin
                    take     = 1'b1;
                    take_idx = 2'd0;
                end else if (!req[owner_q]) begin
                    if (sel_valid) begin
                        take     = 1'b1;
                        take_idx = sel_idx;
                    end else begin
                        state_d  = ST_IDLE;
                        grant_d  = 4'b0000;
                        number_d = IDLE_VALUE;
                        hold_d   = '0;
                    end
                // Rotation is evaluated on the edge the last hold cycle completes.
                end else if (state_q == ST_SLICE || hold_q == CNT_W'(MIN_HOLD - 1)) begin
                    if (owner_q != 2'd0 && rot_rr[2]) begin
                        take     = 1'b1;
                        take_idx = rot_rr[1:0];
                    end else begin
                        state_d = ST_SLICE;
                    end
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
        endcase

        if (take) begin
            state_d  = ST_HOLD;
            grant_d  = 4'b0001 << take_idx;
            owner_d  = take_idx;
            number_d = words[take_idx];
            hold_d   = '0;
            if (take_idx != 2'd0)
                rr_d = take_idx;
        end

        chg_d = (grant_d != grant_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 4'b0000;
            owner_q  <= 2'd0;
            number_q <= IDLE_VALUE;
            chg_q    <= 1'b0;
            hold_q   <= '0;
            rr_q     <= 2'd3;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            number_q <= number_d;
            chg_q    <= chg_d;
            hold_q   <= hold_d;
            rr_q     <= rr_d;
        end
    end

    assign grant  = grant_q;
    assign owner  = owner_q;
    assign busy   = |grant_q;
    assign number = number_q;
    assign chg    = chg_q;

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Scoreboard bench for disp_share_arbiter with MIN_HOLD=4.
module tb_disp_share_arbiter;

    localparam logic [31:0] IDLE_V = 32'hAAAA_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = 4'b0000;
    logic [31:0]  dw [4];
    logic [127:0] data;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic         busy;
    logic [31:0]  number;
    logic         chg;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    typedef struct packed {
        logic [3:0]  g;
        logic [1:0]  o;
        logic [31:0] n;
        logic        c;
    } exp_t;

    exp_t sb [$];

    assign data = {dw[3], dw[2], dw[1], dw[0]};

    always #5 clk = ~clk;

    disp_share_arbiter #(
        .MIN_HOLD   (4),
        .IDLE_VALUE (IDLE_V)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data   (data),
        .grant  (grant),
        .owner  (owner),
        .busy   (busy),
        .number (number),
        .chg    (chg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL txn %0d %s got %h expected %h", txn, tag, got, exp);
        end
    endtask

    // Drive req for one edge, push the expected outcome, then pop and compare it.
    task automatic cyc(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] eo,
                       input logic [31:0] en, input logic ec);
        exp_t e;
        req = r;
        e.g = eg;
        e.o = eo;
        e.n = en;
        e.c = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        txn++;
        $display("txn %0d rst=%b req=%b grant=%b owner=%0d number=%h chg=%b busy=%b",
                 txn, rst, req, grant, owner, number, chg, busy);
        chk("grant",  32'(grant),  32'(e.g));
        chk("owner",  32'(owner),  32'(e.o));
        chk("number", number,      e.n);
        chk("chg",    32'(chg),    32'(e.c));
        chk("busy",   32'(busy),   32'(|e.g));
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        cyc(r, 4'b0000, 2'd0, IDLE_V, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        dw[0] = 32'h0000_00D0;
        dw[1] = 32'h0000_0011;
        dw[2] = 32'h0000_0022;
        dw[3] = 32'h0000_0033;

        do_reset(4'b0000);
        do_reset(4'b0000);

        // Single requester grant, then drop to idle
        dw[1] = 32'h0000_1234;
        cyc(4'b0010, 4'b0010, 2'd1, 32'h0000_1234, 1'b1);
        cyc(4'b0010, 4'b0010, 2'd1, 32'h0000_1234, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd1, IDLE_V, 1'b1);
        cyc(4'b0000, 4'b0000, 2'd1, IDLE_V, 1'b0);
        dw[1] = 32'h0000_0011;

        // Round-robin rotation 1,2,3,1 with 4-cycle slices
        do_reset(4'b0000);
        for (int k = 0; k < 13; k++) begin
            int ow;
            ow = 1 + (k / 4) % 3;
            cyc(4'b1110, 4'(1 << ow), 2'(ow), 32'(ow * 17), 1'((k % 4) == 0));
        end

        // Preemption of owner 2 at hold_cnt=1, then return to requester 3
        do_reset(4'b0000);
        cyc(4'b1100, 4'b0100, 2'd2, 32'h22, 1'b1);
        cyc(4'b1100, 4'b0100, 2'd2, 32'h22, 1'b0);
        cyc(4'b1101, 4'b0001, 2'd0, 32'hD0, 1'b1);
        cyc(4'b1101, 4'b0001, 2'd0, 32'hD0, 1'b0);
        cyc(4'b1100, 4'b1000, 2'd3, 32'h33, 1'b1);

        // Owner 0 is never rotated out
        cyc(4'b1111, 4'b0001, 2'd0, 32'hD0, 1'b1);
        for (int k = 0; k < 20; k++)
            cyc(4'b1111, 4'b0001, 2'd0, 32'hD0, 1'b0);
        cyc(4'b1110, 4'b0010, 2'd1, 32'h11, 1'b1);

        // Data tracking with one-cycle latency, then drop to idle
        do_reset(4'b0000);
        dw[1] = 32'h5;
        for (int c = 1; c <= 10; c++) begin
            if (c == 8)
                dw[1] = 32'h6;
            cyc(4'b0010, 4'b0010, 2'd1, (c >= 8) ? 32'h6 : 32'h5, 1'(c == 1));
        end
        cyc(4'b0000, 4'b0000, 2'd1, IDLE_V, 1'b1);
        dw[1] = 32'h11;

        // Simultaneous owner drop and req[0] rise: preemption wins
        cyc(4'b0010, 4'b0010, 2'd1, 32'h11, 1'b1);
        cyc(4'b0101, 4'b0001, 2'd0, 32'hD0, 1'b1);

        // Requester 0 wins from idle over others
        do_reset(4'b0000);
        cyc(4'b0011, 4'b0001, 2'd0, 32'hD0, 1'b1);

        // Reset during ownership by 3, then rr_last restarts at 3
        do_reset(4'b0000);
        cyc(4'b1000, 4'b1000, 2'd3, 32'h33, 1'b1);
        cyc(4'b1000, 4'b1000, 2'd3, 32'h33, 1'b0);
        do_reset(4'b1000);
        cyc(4'b1010, 4'b0010, 2'd1, 32'h11, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_share_arbiter.md
Name: disp_share_arbiter

Overview:
- Shares the single 8-digit seven-segment scan driver between four requesters: alert/message, game stats, clock and debug.
- Produces the 32-bit packed-BCD word fed to the driver's number input. It also produces a one-hot grant and a change pulse.
- Requester 0 has absolute priority. Requesters 1-3 rotate round-robin, each holding the display for a guaranteed minimum time.
- Sits between the application logic and the display driver, in the same clk domain.

Parameters:
- MIN_HOLD, 100_000_000: minimum number of cycles an owner of class 1-3 keeps the display before rotation. Must be at least 1.
- IDLE_VALUE, 32'h0000_0000: word driven when nobody owns the display.
- CNT_W, $clog2(MIN_HOLD+1): width of the hold counter.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, synchronous, active-high.
- req, input, 4: request per requester; level, held high while the requester wants the display.
- data, input, 128: packed words; requester i drives data[32*i+31:32*i].
- grant, output, 4: one-hot owner, or all zero when idle; registered.
- owner, output, 2: index of the current owner; holds the last value when idle.
- busy, output, 1: high while any grant bit is high.
- number, output, 32: word to the display driver; registered.
- chg, output, 1: one-cycle pulse on the cycle grant changes value, including to and from zero.

Behaviour:
- Reset, checked first every edge: grant=0, owner=0, busy=0, number=IDLE_VALUE, chg=0, hold_cnt=0, rr_last=3, state=IDLE. Reset mid-operation aborts ownership immediately; no chg pulse is issued on that edge.
- Winner selection (combinational, on current req):
  - If req[0]=1, the winner is 0.
  - Otherwise search 1..3 starting at rr_last+1, wrapping 3->1; the first requester found wins.
  - The search excludes the current owner only when a rotation is being evaluated.
- State IDLE:
  - If req=0: stay in IDLE, number=IDLE_VALUE.
  - Otherwise, on the next edge: grant=onehot(winner), owner=winner, number=data[winner] (sampled the same edge), hold_cnt=0, chg=1, state=HOLD. If winner is 1-3, rr_last=winner.
- State HOLD:
  - Each cycle: number<=data[owner], giving 1-cycle latency from data to number; hold_cnt increments.
  - Owner drops req: re-select on that edge. Go directly to the new winner (chg=1, hold_cnt=0), or to IDLE if req=0 (grant=0, number=IDLE_VALUE, chg=1).
  - req[0] rises while owner!=0: preempt on that edge. Grant 0, chg=1, hold_cnt=0; rr_last unchanged.
  - When hold_cnt reaches MIN_HOLD-1 and the owner is still requesting: go to SLICE.
- State SLICE (minimum hold satisfied):
  - Owner 0 is never rotated out by 1-3; it leaves only by dropping req.
  - Owner 1-3: if another requester among 1..3 is requesting, switch to the next one round-robin on that edge (chg=1, hold_cnt=0, state=HOLD, rr_last=new owner).
  - If nobody else is requesting, stay in SLICE indefinitely; number keeps tracking data[owner].
  - Drop and preempt rules are the same as in HOLD.
- Simultaneous events on one edge, in priority order: reset > req[0] preempt > owner drop > rotation.
- A requester whose req and grant are both high owns the display. Requesters must not assume ownership before grant is seen.
- grant changes owner-to-owner with no idle gap. Exactly one grant bit is high when busy=1.

Test Plan (MIN_HOLD=4):
- Reset, then req=4'b0010 with data1=32'h0000_1234 -> grant=4'b0010 one cycle later; number=32'h0000_1234 on the same cycle; chg pulses once; busy=1.
- req=4'b1110 held, data1/2/3=0x11,0x22,0x33 -> owner sequence 1,2,3,1,... Each owner holds exactly 4 cycles before switching; chg pulses at every switch.
- Owner 2 in HOLD at hold_cnt=1, req[0] rises -> next edge grant=4'b0001, number=data0. When req[0] falls, requester 3 is granted (rr_last=2 retained).
- Owner 0 with req=4'b1111 held for 20 cycles -> grant stays 4'b0001, no chg. Drop req[0] -> next edge grant moves to the next round-robin requester.
- Owner 1 alone for 10 cycles, data1 changed from 0x5 to 0x6 at cycle 7 -> number shows 0x6 at cycle 8, grant unchanged. Drop req -> grant=0, number=IDLE_VALUE, chg=1.
- Assert rst while owner=3 in HOLD -> next edge grant=0, number=IDLE_VALUE, chg=0. After release with req=4'b1010, requester 1 is granted first (rr_last reset to 3).
